// File: rtl/phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : phase_sequencer
// Description : Four-phase enable sequencer (en_a arm, then exclusive
//               en_b -> en_c -> en_d phases) with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_sequencer #(
  parameter int unsigned START_DLY = 3,
  parameter int unsigned PHASE_LEN = 4,
  parameter int unsigned LEN_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             en_a,
  output logic             en_b,
  output logic             en_c,
  output logic             en_d,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    PH_B = 3'd2,
    PH_C = 3'd3,
    PH_D = 3'd4
  } state_t;

  localparam logic [LEN_W-1:0] C_START_DLY = LEN_W'(START_DLY);
  localparam logic [LEN_W-1:0] C_PHASE_LEN = LEN_W'(PHASE_LEN);
  localparam logic [LEN_W-1:0] C_ONE       = LEN_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] w_cnt_nxt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] w_len_nxt;
  logic             w_done_nxt;
  logic             w_last;

  // Counter holds the remaining edges of the current state; the state ends
  // on the edge where it reads 1, so it never reaches zero or wraps.
  assign w_last = (r_cnt <= C_ONE);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_len_nxt   = (cfg_len == '0) ? C_PHASE_LEN : cfg_len;
          w_cnt_nxt   = C_START_DLY;
          w_state_nxt = ARM;
        end
      end
      ARM, PH_B, PH_C: begin
        if (w_last) begin
          w_cnt_nxt   = r_len;
          w_state_nxt = (r_state == ARM)  ? PH_B :
                        (r_state == PH_B) ? PH_C : PH_D;
        end else begin
          w_cnt_nxt = r_cnt - C_ONE;
        end
      end
      PH_D: begin
        if (w_last) begin
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - C_ONE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
    // Abort overrides any in-flight transition, including the final one.
    if (abort && (r_state != IDLE)) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      en_a    <= 1'b0;
      en_b    <= 1'b0;
      en_c    <= 1'b0;
      en_d    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
      en_a    <= (w_state_nxt != IDLE);
      en_b    <= (w_state_nxt == PH_B);
      en_c    <= (w_state_nxt == PH_C);
      en_d    <= (w_state_nxt == PH_D);
      busy    <= (w_state_nxt != IDLE);
      done    <= w_done_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_phase_sequencer
// Description : Scoreboard bench for phase_sequencer; expected output changes
//               are queued by the stimulus and matched by a negedge monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_sequencer;

  localparam logic [5:0] V_IDLE = 6'b000000;  // {busy,a,b,c,d,done}
  localparam logic [5:0] V_A    = 6'b110000;
  localparam logic [5:0] V_B    = 6'b111000;
  localparam logic [5:0] V_C    = 6'b110100;
  localparam logic [5:0] V_D    = 6'b110010;
  localparam logic [5:0] V_DONE = 6'b000001;

  typedef struct {
    int         cyc;
    logic [5:0] vec;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] cfg_len;
  logic       en_a, en_b, en_c, en_d, busy, done;

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  bit         sb_on = 1'b0;
  logic [5:0] prev = 6'b000000;
  ev_t        exp_q[$];

  phase_sequencer #(
    .START_DLY(3),
    .PHASE_LEN(4),
    .LEN_W    (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .abort  (abort),
    .cfg_len(cfg_len),
    .en_a   (en_a),
    .en_b   (en_b),
    .en_c   (en_c),
    .en_d   (en_d),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit inv_ok(input logic [5:0] v);
    return ($countones(v[3:1]) <= 1) &&
           (!(|v[3:1]) || v[4]) &&
           (!v[0] || !(|v[4:1])) &&
           (v[5] == v[4]);
  endfunction

  // Monitor: every change of the output vector must match the next queued event.
  always @(negedge clk) begin
    logic [5:0] vec;
    ev_t        e;
    vec = {busy, en_a, en_b, en_c, en_d, done};
    if (!$isunknown(vec)) begin
      checks++;
      if (!inv_ok(vec)) begin
        errors++;
        $display("FAIL invariant cyc=%0d got=%b", cyc, vec);
      end
    end
    if (sb_on && (vec !== prev)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, vec);
      end else begin
        e = exp_q.pop_front();
        if ((e.cyc != cyc) || (e.vec !== vec)) begin
          errors++;
          $display("FAIL output_event got cyc=%0d vec=%b required cyc=%0d vec=%b",
                   cyc, vec, e.cyc, e.vec);
        end
      end
    end
    prev = vec;
  end

  task automatic push_ev(input int c, input logic [5:0] v);
    ev_t e;
    e.cyc = c;
    e.vec = v;
    exp_q.push_back(e);
  endtask

  // Sequence accepted at edge n with phase length len (START_DLY = 3).
  task automatic push_seq(input int n, input int len, input bit tail);
    push_ev(n, V_A);
    push_ev(n + 3, V_B);
    push_ev(n + 3 + len, V_C);
    push_ev(n + 3 + 2 * len, V_D);
    push_ev(n + 3 + 3 * len, V_DONE);
    if (tail) push_ev(n + 4 + 3 * len, V_IDLE);
  endtask

  task automatic begin_start(input logic [7:0] len, output int n);
    start   = 1'b1;
    cfg_len = len;
    n       = cyc + 1;
  endtask

  task automatic end_start();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic chk_vec(input string name, input logic [5:0] req);
    logic [5:0] vec;
    vec = {busy, en_a, en_b, en_c, en_d, done};
    checks++;
    if (vec !== req) begin
      errors++;
      $display("FAIL %s got=%b required=%b", name, vec, req);
    end
  endtask

  initial begin
    int n;
    int n2;
    rst     = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    cfg_len = 8'd0;
    repeat (3) @(negedge clk);
    chk_vec("reset_state", V_IDLE);
    rst = 1'b0;
    @(negedge clk);
    chk_vec("idle_after_reset", V_IDLE);
    sb_on = 1'b1;

    // Default length sequence.
    begin_start(8'd0, n);
    push_seq(n, 4, 1'b1);
    end_start();
    wait_to(n + 18);

    // cfg_len = 2, changed to 7 while busy.
    begin_start(8'd2, n);
    push_seq(n, 2, 1'b1);
    end_start();
    wait_to(n + 4);
    cfg_len = 8'd7;
    wait_to(n + 12);
    cfg_len = 8'd0;

    // Start re-pulsed while busy, then held in the done cycle.
    begin_start(8'd0, n);
    push_seq(n, 4, 1'b0);
    push_seq(n + 16, 4, 1'b1);
    end_start();
    wait_to(n + 3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_to(n + 7);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_to(n + 15);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_to(n + 16 + 18);

    // Abort during PH_C, then a fresh full sequence.
    begin_start(8'd0, n);
    push_ev(n, V_A);
    push_ev(n + 3, V_B);
    push_ev(n + 7, V_C);
    push_ev(n + 9, V_IDLE);
    end_start();
    wait_to(n + 8);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (2) @(negedge clk);
    begin_start(8'd0, n2);
    push_seq(n2, 4, 1'b1);
    end_start();
    wait_to(n2 + 18);

    // Abort in IDLE alone has no effect.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    chk_vec("abort_in_idle", V_IDLE);

    // Reset mid-sequence.
    begin_start(8'd0, n);
    push_ev(n, V_A);
    push_ev(n + 3, V_B);
    push_ev(n + 7, V_C);
    push_ev(n + 9, V_IDLE);
    end_start();
    wait_to(n + 8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_vec("reset_mid_sequence", V_IDLE);
    repeat (3) @(negedge clk);

    // Start together with abort in IDLE: dropped.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (6) @(negedge clk);
    chk_vec("start_abort_idle", V_IDLE);

    // Random traffic, invariants only.
    sb_on = 1'b0;
    for (int i = 0; i < 200; i++) begin
      start   = ($urandom_range(0, 3) == 0);
      abort   = ($urandom_range(0, 15) == 0);
      cfg_len = 8'($urandom_range(0, 3));
      @(negedge clk);
    end
    start   = 1'b0;
    abort   = 1'b0;
    cfg_len = 8'd0;
    rst     = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_vec("reset_after_random", V_IDLE);
    sb_on = 1'b1;

    // Recovery with a length-1 sequence.
    begin_start(8'd1, n);
    push_seq(n, 1, 1'b1);
    end_start();
    wait_to(n + 10);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events got=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
